ccd_scan_averager: RTL and testbench

Parametrised pixel acquisition buffer that sits between the AD7621 sample path and the MCU-facing SPI readout. It applies offset subtraction and saturation clamping to each CCD pixel, then accumulates 1 to 2^MAX_AVG_LOG2 consecutive ILX511B scans in an on-chip RAM. The finished frame is presented as a pop-on-request pixel stream with a `pixel_ready` level. It supersedes the single-scan FIFO path with configurable frame length, sample width and scan averaging.

---
 rtl/ccd_scan_averager.sv | 229 ++++++++++++++++++++++
 tb/tb_ccd_scan_averager.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_scan_averager.sv
// ccd_scan_averager
// Pixel acquisition buffer between the ADC sample path and the SPI readout.
// Every sample has the dark offset subtracted and is clamped to a ceiling.
// 2^n consecutive scans are then summed per pixel in an on-chip RAM, and the
// finished frame is read back as a pop-on-request stream of averaged pixels.
//
// Ports:
//   sys_clk, sys_rst    clock, synchronous active-high reset
//   frame_start         start/restart a frame (highest priority input)
//   avg_log2            log2 of scans to average, sampled on frame_start
//   offset_value        dark offset subtracted from each sample
//   max_sat_value       clamp ceiling applied after subtraction
//   pix_valid, pix_data incoming ADC sample strobe and value
//   rd_req              pop one averaged pixel
//   rd_data, rd_valid   popped pixel, valid one cycle after rd_req
//   pixel_ready         unread pixels remain
//   busy                acquiring scans
//   frame_done          one-cycle pulse when readout becomes available
//   overrun             sticky: a sample was dropped
//   sat_count           clamped samples in the frame
//
// Build option: define PIXEL_SAT_COUNT_EN to enable the saturation counter;
// otherwise sat_count is tied to 0.
//
// state   | meaning
// IDLE    | no frame; samples are dropped
// ACQ     | accumulating scans into RAM (scan_idx, pix_idx)
// READOUT | frame complete, pixels popped by rd_req (rd_addr)

module ccd_scan_averager #(
   parameter int DATA_W       = 16,
   parameter int PIX_COUNT    = 2048,
   parameter int MAX_AVG_LOG2 = 4,
   parameter int ACC_W        = DATA_W + MAX_AVG_LOG2
) (
   input  logic                           sys_clk,
   input  logic                           sys_rst,
   input  logic                           frame_start,
   input  logic [2:0]                     avg_log2,
   input  logic [DATA_W-1:0]              offset_value,
   input  logic [DATA_W-1:0]              max_sat_value,
   input  logic                           pix_valid,
   input  logic [DATA_W-1:0]              pix_data,
   input  logic                           rd_req,
   output logic [DATA_W-1:0]              rd_data,
   output logic                           rd_valid,
   output logic                           pixel_ready,
   output logic                           busy,
   output logic                           frame_done,
   output logic                           overrun,
   output logic [$clog2(PIX_COUNT+1)-1:0] sat_count
);

   localparam int PIX_W = (PIX_COUNT > 1) ? $clog2(PIX_COUNT) : 1;
   localparam int RA_W  = $clog2(PIX_COUNT + 1);
   localparam int SI_W  = MAX_AVG_LOG2 + 1;
   localparam int SAT_W = RA_W;

   typedef enum logic [1:0] {S_IDLE, S_ACQ, S_READOUT} state_t;

   state_t            state_q, state_d;
   logic [2:0]        n_log2_q, n_log2_d;
   logic [SI_W-1:0]   scan_idx_q, scan_idx_d;
   logic [PIX_W-1:0]  pix_idx_q, pix_idx_d;
   logic [RA_W-1:0]   rd_addr_q, rd_addr_d;
   logic              overrun_q, overrun_d;
   logic              wr_pend_q, wr_pend_d;
   logic              wr_first_q, wr_first_d;
   logic              wr_last_q, wr_last_d;
   logic [PIX_W-1:0]  wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_c_q, wr_c_d;
   logic              rd_valid_q, rd_valid_d;
   logic              frame_done_q, frame_done_d;

   logic [ACC_W-1:0]  mem [PIX_COUNT];
   logic [ACC_W-1:0]  ram_rdata_q;
   logic [ACC_W-1:0]  ram_wdata;
   logic [PIX_W-1:0]  ram_raddr;
   logic              ram_re;

   logic              pix_accept, pix_drop, rd_accept, rd_avail;
   logic              pix_last, scan_last;
   logic [SI_W-1:0]   scan_max;
   logic [DATA_W-1:0] corr_base, corr_val;
   logic              corr_clamp;

   // accepted samples must be spaced 2 cycles so the RMW write lands before
   // the next read; a sample during the write cycle is dropped
   always_comb begin
      rd_avail   = (state_q == S_READOUT) && (rd_addr_q < RA_W'(PIX_COUNT));
      pix_accept = !frame_start && (state_q == S_ACQ) && pix_valid && !wr_pend_q;
      pix_drop   = !frame_start && pix_valid && !pix_accept;
      rd_accept  = !frame_start && rd_avail && rd_req;
      pix_last   = (pix_idx_q == PIX_W'(PIX_COUNT - 1));
      scan_max   = SI_W'((SI_W'(1) << n_log2_q) - SI_W'(1));
      scan_last  = (scan_idx_q == scan_max);
      corr_base  = (pix_data < offset_value) ? '0 : pix_data - offset_value;
      corr_clamp = (corr_base > max_sat_value);
      corr_val   = corr_clamp ? max_sat_value : corr_base;
   end

   // FSM: state register
   always_ff @(posedge sys_clk) begin
      if (sys_rst) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (frame_start) begin
         state_d = S_ACQ;
      end else begin
         case (state_q)
            S_ACQ:     if (wr_pend_q && wr_last_q) state_d = S_READOUT;
            S_READOUT: if (rd_accept && (rd_addr_q == RA_W'(PIX_COUNT - 1))) state_d = S_IDLE;
            default:   state_d = state_q;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      busy        = (state_q == S_ACQ);
      pixel_ready = rd_avail;
      frame_done  = frame_done_q;
      rd_valid    = rd_valid_q;
      rd_data     = rd_valid_q ? DATA_W'(ram_rdata_q >> n_log2_q) : '0;
      overrun     = overrun_q;
   end

   always_comb begin
      n_log2_d     = n_log2_q;
      scan_idx_d   = scan_idx_q;
      pix_idx_d    = pix_idx_q;
      rd_addr_d    = rd_addr_q;
      overrun_d    = overrun_q;
      wr_pend_d    = pix_accept;
      wr_first_d   = (scan_idx_q == '0);
      wr_last_d    = pix_last && scan_last;
      wr_addr_d    = pix_idx_q;
      wr_c_d       = corr_val;
      rd_valid_d   = rd_accept;
      frame_done_d = (state_q == S_ACQ) && (state_d == S_READOUT);
      if (frame_start) begin
         if (int'(avg_log2) > MAX_AVG_LOG2) n_log2_d = 3'(MAX_AVG_LOG2);
         else                               n_log2_d = avg_log2;
         scan_idx_d = '0;
         pix_idx_d  = '0;
         rd_addr_d  = '0;
         overrun_d  = 1'b0;
      end else begin
         if (pix_accept) begin
            if (pix_last) begin
               pix_idx_d  = '0;
               scan_idx_d = scan_idx_q + SI_W'(1);
            end else begin
               pix_idx_d = pix_idx_q + PIX_W'(1);
            end
         end
         if (pix_drop)  overrun_d = 1'b1;
         if (rd_accept) rd_addr_d = rd_addr_q + RA_W'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         n_log2_q     <= '0;
         scan_idx_q   <= '0;
         pix_idx_q    <= '0;
         rd_addr_q    <= '0;
         overrun_q    <= 1'b0;
         wr_pend_q    <= 1'b0;
         wr_first_q   <= 1'b0;
         wr_last_q    <= 1'b0;
         wr_addr_q    <= '0;
         wr_c_q       <= '0;
         rd_valid_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         n_log2_q     <= n_log2_d;
         scan_idx_q   <= scan_idx_d;
         pix_idx_q    <= pix_idx_d;
         rd_addr_q    <= rd_addr_d;
         overrun_q    <= overrun_d;
         wr_pend_q    <= wr_pend_d;
         wr_first_q   <= wr_first_d;
         wr_last_q    <= wr_last_d;
         wr_addr_q    <= wr_addr_d;
         wr_c_q       <= wr_c_d;
         rd_valid_q   <= rd_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // scan 0 overwrites instead of adding, so the RAM never needs clearing
   always_comb begin
      ram_wdata = wr_first_q ? ACC_W'(wr_c_q) : ram_rdata_q + ACC_W'(wr_c_q);
      ram_re    = pix_accept || rd_accept;
      ram_raddr = (state_q == S_READOUT) ? rd_addr_q[PIX_W-1:0] : pix_idx_q;
   end

   always_ff @(posedge sys_clk) begin
      if (wr_pend_q) mem[wr_addr_q] <= ram_wdata;
      if (ram_re)    ram_rdata_q    <= mem[ram_raddr];
   end

`ifdef PIXEL_SAT_COUNT_EN
   logic [SAT_W-1:0] sat_cnt_q, sat_cnt_d;

   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (frame_start)
         sat_cnt_d = '0;
      else if (pix_accept && corr_clamp && (sat_cnt_q != '1))
         sat_cnt_d = sat_cnt_q + SAT_W'(1);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) sat_cnt_q <= '0;
      else         sat_cnt_q <= sat_cnt_d;
   end

   assign sat_count = sat_cnt_q;
`else
   assign sat_count = '0;
`endif

endmodule

// File: tb/tb_ccd_scan_averager.sv
module tb_ccd_scan_averager;

   localparam int DW   = 16;
   localparam int PIX  = 32;
   localparam int MAXL = 4;
   localparam int SW   = $clog2(PIX + 1);

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          sys_rst, frame_start, pix_valid, rd_req;
   logic [2:0]    avg_log2;
   logic [DW-1:0] offset_value, max_sat_value, pix_data, rd_data;
   logic          rd_valid, pixel_ready, busy, frame_done, overrun;
   logic [SW-1:0] sat_count;

   ccd_scan_averager #(.DATA_W(DW), .PIX_COUNT(PIX), .MAX_AVG_LOG2(MAXL)) dut (
      .sys_clk(clk), .sys_rst(sys_rst), .frame_start(frame_start), .avg_log2(avg_log2),
      .offset_value(offset_value), .max_sat_value(max_sat_value),
      .pix_valid(pix_valid), .pix_data(pix_data), .rd_req(rd_req),
      .rd_data(rd_data), .rd_valid(rd_valid), .pixel_ready(pixel_ready), .busy(busy),
      .frame_done(frame_done), .overrun(overrun), .sat_count(sat_count)
   );

   int checks = 0, errors = 0, fd_cnt = 0, rv_cnt = 0;
   logic [15:0] exp_q[$];
   int unsigned acc[PIX];
   int cur_n = 0;
   int g_sat = 0;

   // scoreboard: every rd_valid pops one expected pixel
   always @(negedge clk) begin : mon
      logic [15:0] e;
      if (frame_done === 1'b1) fd_cnt++;
      if (rd_valid === 1'b1) begin
         rv_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rd_valid: got rd_data=%0d, required no rd_valid", rd_data);
         end else begin
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               errors++;
               $display("FAIL rd_data: got %0d, required %0d", rd_data, e);
            end
         end
      end
   end

   function automatic logic [16:0] corr(input logic [15:0] raw);
      logic [15:0] c;
      c = (raw < offset_value) ? 16'd0 : raw - offset_value;
      if (c > max_sat_value) return {1'b1, max_sat_value};
      return {1'b0, c};
   endfunction

   function automatic int exp_sat();
`ifdef PIXEL_SAT_COUNT_EN
      return g_sat;
`else
      return 0;
`endif
   endfunction

   task automatic start_frame(input logic [2:0] a);
      @(posedge clk); #1;
      frame_start = 1'b1; avg_log2 = a;
      cur_n = (int'(a) > MAXL) ? MAXL : int'(a);
      g_sat = 0;
      @(posedge clk); #1;
      frame_start = 1'b0;
   endtask

   task automatic send_pixel(input logic [15:0] v);
      @(posedge clk); #1;
      pix_valid = 1'b1; pix_data = v;
      @(posedge clk); #1;
      pix_valid = 1'b0;
   endtask

   task automatic send_model(input int i, input int k, input logic [15:0] raw);
      logic [16:0] r;
      r = corr(raw);
      if (r[16]) g_sat++;
      acc[i] = ((k == 0) ? 0 : acc[i]) + int'(r[15:0]);
      send_pixel(raw);
   endtask

   // returns {frame_done,busy} in T+1 and {frame_done,pixel_ready,busy} in T+2
   task automatic wait_frame_end(output logic [1:0] t1, output logic [2:0] t2);
      @(negedge clk); t1 = {frame_done, busy};
      @(negedge clk); t2 = {frame_done, pixel_ready, busy};
   endtask

   // back-to-back pops; returns {rd_valid,pixel_ready} the cycle after the last pop
   task automatic pop_n(input int start, input int n, output logic [1:0] last_obs);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         rd_req = 1'b1;
         exp_q.push_back(16'(acc[start + i] >> cur_n));
      end
      @(posedge clk); #1;
      rd_req = 1'b0;
      @(negedge clk); last_obs = {rd_valid, pixel_ready};
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset;
      sys_rst = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      sys_rst = 1'b0;
      @(negedge clk);
      checks++; if (rd_valid !== 1'b0)    begin errors++; $display("FAIL rst_rd_valid: got %b, required 0", rd_valid); end
      checks++; if (rd_data !== 16'd0)    begin errors++; $display("FAIL rst_rd_data: got %0d, required 0", rd_data); end
      checks++; if (pixel_ready !== 1'b0) begin errors++; $display("FAIL rst_pixel_ready: got %b, required 0", pixel_ready); end
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
      checks++; if (frame_done !== 1'b0)  begin errors++; $display("FAIL rst_frame_done: got %b, required 0", frame_done); end
      checks++; if (overrun !== 1'b0)     begin errors++; $display("FAIL rst_overrun: got %b, required 0", overrun); end
      checks++; if (sat_count !== '0)     begin errors++; $display("FAIL rst_sat_count: got %0d, required 0", sat_count); end
   endtask

   task automatic test_single_scan;
      int fd0, rv0; logic [1:0] t1, lp; logic [2:0] t2;
      offset_value = 16'd100; max_sat_value = 16'd60000;
      start_frame(3'd0);
      fd0 = fd_cnt; rv0 = rv_cnt;
      for (int i = 0; i < PIX; i++) send_model(i, 0, 16'(i + 100));
      wait_frame_end(t1, t2);
      checks++; if (t1 !== 2'b01)  begin errors++; $display("FAIL single_t1 {frame_done,busy}: got %b, required 01", t1); end
      checks++; if (t2 !== 3'b110) begin errors++; $display("FAIL single_t2 {frame_done,pixel_ready,busy}: got %b, required 110", t2); end
      pop_n(0, PIX, lp);
      checks++; if (lp !== 2'b10)  begin errors++; $display("FAIL single_last_pop {rd_valid,pixel_ready}: got %b, required 10", lp); end
      checks++; if (rv_cnt - rv0 != PIX) begin errors++; $display("FAIL single_pops: got %0d, required %0d", rv_cnt - rv0, PIX); end
      checks++; if (fd_cnt - fd0 != 1)   begin errors++; $display("FAIL single_frame_done_count: got %0d, required 1", fd_cnt - fd0); end
      checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL single_overrun: got %b, required 0", overrun); end
      checks++; if (busy !== 1'b0 || pixel_ready !== 1'b0) begin errors++; $display("FAIL single_idle {busy,pixel_ready}: got %b%b, required 00", busy, pixel_ready); end
   endtask

   task automatic test_four_scan_avg;
      int rv0; logic [1:0] t1, lp; logic [2:0] t2;
      offset_value = 16'd0; max_sat_value = 16'd60000;
      start_frame(3'd2);
      rv0 = rv_cnt;
      for (int k = 0; k < 4; k++)
         for (int i = 0; i < PIX; i++) send_model(i, k, 16'(1000 + k + 3 * i));
      wait_frame_end(t1, t2);
      checks++; if (t2 !== 3'b110) begin errors++; $display("FAIL avg4_frame_end: got %b, required 110", t2); end
      pop_n(0, PIX, lp);
      checks++; if (lp !== 2'b10)  begin errors++; $display("FAIL avg4_last_pop: got %b, required 10", lp); end
      checks++; if (rv_cnt - rv0 != PIX) begin errors++; $display("FAIL avg4_pops: got %0d, required %0d", rv_cnt - rv0, PIX); end
   endtask

   task automatic test_clamp;
      logic [1:0] t1, lp; logic [2:0] t2; logic [15:0] raw;
      offset_value = 16'd500; max_sat_value = 16'd1000;
      start_frame(3'd0);
      for (int i = 0; i < PIX; i++) begin
         case (i)
            0: raw = 16'd200;
            1: raw = 16'd500;
            2: raw = 16'd2000;
            3: raw = 16'd1500;
            4: raw = 16'd1501;
            default: raw = 16'(500 + 10 * i);
         endcase
         send_model(i, 0, raw);
      end
      wait_frame_end(t1, t2);
      checks++; if (int'(sat_count) != exp_sat()) begin errors++; $display("FAIL clamp_sat_count: got %0d, required %0d", sat_count, exp_sat()); end
      pop_n(0, PIX, lp);
      checks++; if (int'(sat_count) != exp_sat()) begin errors++; $display("FAIL clamp_sat_hold: got %0d, required %0d", sat_count, exp_sat()); end
   endtask

   task automatic test_restart;
      logic [1:0] t1, lp; logic [2:0] t2;
      offset_value = 16'd0; max_sat_value = 16'd60000;
      start_frame(3'd2);
      for (int i = 0; i < PIX; i++)     send_model(i, 0, 16'd7777);
      for (int i = 0; i < PIX / 2; i++) send_model(i, 1, 16'd5555);
      start_frame(3'd2);
      @(negedge clk);
      checks++; if ({busy, pixel_ready} !== 2'b10) begin errors++; $display("FAIL restart_acq {busy,pixel_ready}: got %b, required 10", {busy, pixel_ready}); end
      for (int k = 0; k < 4; k++)
         for (int i = 0; i < PIX; i++) send_model(i, k, 16'(200 + i + k));
      wait_frame_end(t1, t2);
      checks++; if (t2 !== 3'b110) begin errors++; $display("FAIL restart_frame_end: got %b, required 110", t2); end
      pop_n(0, 5, lp);
      checks++; if (lp !== 2'b11) begin errors++; $display("FAIL restart_partial {rd_valid,pixel_ready}: got %b, required 11", lp); end
      // restart while reading out: the remaining pixels are discarded
      start_frame(3'd0);
      @(negedge clk);
      checks++; if ({busy, pixel_ready, rd_valid} !== 3'b100) begin errors++; $display("FAIL restart_readout: got %b, required 100", {busy, pixel_ready, rd_valid}); end
      for (int i = 0; i < PIX; i++) send_model(i, 0, 16'(3 * i + 1));
      wait_frame_end(t1, t2);
      pop_n(0, PIX, lp);
      checks++; if (lp !== 2'b10) begin errors++; $display("FAIL restart_last_pop: got %b, required 10", lp); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL restart_drain: got %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_overrun;
      int rv0; logic [1:0] t1, lp; logic [2:0] t2; logic [16:0] r;
      offset_value = 16'd0; max_sat_value = 16'd60000;
      rv0 = rv_cnt;
      @(posedge clk); #1; rd_req = 1'b1;
      repeat (3) @(posedge clk);
      #1; rd_req = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (rv_cnt != rv0)   begin errors++; $display("FAIL idle_rd_req_pops: got %0d, required 0", rv_cnt - rv0); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL idle_rd_req_overrun: got %b, required 0", overrun); end
      send_pixel(16'd123);
      @(negedge clk);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL idle_pix_overrun: got %b, required 1", overrun); end
      start_frame(3'd0);
      @(negedge clk);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b, required 0", overrun); end
      r = corr(16'd11);
      acc[0] = int'(r[15:0]);
      @(posedge clk); #1; pix_valid = 1'b1; pix_data = 16'd11;
      @(posedge clk); #1; pix_data = 16'd99;
      @(posedge clk); #1; pix_valid = 1'b0;
      @(negedge clk);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_consecutive: got %b, required 1", overrun); end
      for (int i = 1; i < PIX; i++) send_model(i, 0, 16'(2 * i));
      wait_frame_end(t1, t2);
      checks++; if (t2 !== 3'b110) begin errors++; $display("FAIL overrun_frame_end: got %b, required 110", t2); end
      pop_n(0, PIX, lp);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b, required 1", overrun); end
   endtask

   task automatic test_reset_readout;
      int rv0; logic [1:0] t1, lp; logic [2:0] t2;
      offset_value = 16'd0; max_sat_value = 16'd20;
      start_frame(3'd0);
      for (int i = 0; i < PIX; i++) send_model(i, 0, 16'(i + 5));
      wait_frame_end(t1, t2);
      checks++; if (int'(sat_count) != exp_sat()) begin errors++; $display("FAIL rr_sat_count: got %0d, required %0d", sat_count, exp_sat()); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         rd_req = 1'b1;
         pix_valid = (i == 3);
         exp_q.push_back(16'(acc[i] >> cur_n));
      end
      @(posedge clk); #1;
      pix_valid = 1'b0; sys_rst = 1'b1;
      @(negedge clk);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL rr_overrun_readout: got %b, required 1", overrun); end
      @(posedge clk); #1;
      sys_rst = 1'b0;
      @(negedge clk);
      checks++; if ({rd_valid, pixel_ready, busy, frame_done, overrun} !== 5'b0) begin errors++; $display("FAIL rr_flags: got %b, required 00000", {rd_valid, pixel_ready, busy, frame_done, overrun}); end
      checks++; if (rd_data !== 16'd0 || sat_count !== '0) begin errors++; $display("FAIL rr_data: got rd_data=%0d sat_count=%0d, required 0 0", rd_data, sat_count); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_ten_pops: got %0d left, required 0", exp_q.size()); end
      rv0 = rv_cnt;
      repeat (4) @(posedge clk);
      start_frame(3'd0);
      repeat (4) @(posedge clk);
      #1; rd_req = 1'b0;
      @(negedge clk);
      checks++; if (rv_cnt != rv0) begin errors++; $display("FAIL rr_rd_req_ignored: got %0d pops, required 0", rv_cnt - rv0); end
      for (int i = 0; i < PIX; i++) send_model(i, 0, 16'(i + 9));
      wait_frame_end(t1, t2);
      checks++; if (t2 !== 3'b110) begin errors++; $display("FAIL rr_frame_end: got %b, required 110", t2); end
      pop_n(0, PIX, lp);
      checks++; if (rv_cnt - rv0 != PIX) begin errors++; $display("FAIL rr_pops: got %0d, required %0d", rv_cnt - rv0, PIX); end
   endtask

   initial begin
      sys_rst = 1'b1; frame_start = 1'b0; avg_log2 = 3'd0;
      offset_value = '0; max_sat_value = '0;
      pix_valid = 1'b0; pix_data = '0; rd_req = 1'b0;
      test_reset();
      test_single_scan();
      test_four_scan_avg();
      test_clamp();
      test_restart();
      test_overrun();
      test_reset_readout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
